instr_loader: RTL and testbench
===============================

# instr_loader

Program loader that writes the instruction memory from a byte stream, so a new program can be loaded without rebuilding the memory's hex preload. It receives a little-endian framed stream over a valid/ready byte interface and packs it into 32-bit words. It drives a word-aligned write port on the instruction memory. It holds the core in reset (`core_hold`) for the whole load.

## Interface
- `DATA_WIDTH`, 32: instruction word width; fixed at 4 bytes.
- `ADDR_WIDTH`, 32: byte-address width of `mem_addr`.
- `MEM_SIZE`, 512: instruction memory depth in words.
- `BASE_ADDR`, 0: byte address of the first loaded word; must be word-aligned.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that starts a load session.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  byte address, word-aligned; the memory indexes it with `[ADDR_WIDTH-1:2]`.
- `mem_wdata`  out  DATA_WIDTH  word to write.
- `core_hold`  out  1  keeps the CPU core in reset while high.
- `busy`  out  1  a load session is in progress.
- `done`  out  1  last session completed without error.
- `err`  out  1  last session was rejected.

## Operation
- Frame format: a 4-byte word count N, then N×4 payload bytes. Every multi-byte field is sent least-significant byte first.
- Byte transfer: a byte moves on a rising edge where `rx_valid && rx_ready` is high. `rx_data` is sampled on that edge.
- FSM states: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE:
  - `rx_ready`=0 and `core_hold`=0.
  - `start` moves to LEN and clears the byte counter, word counter and length register.
- LEN:
  - `rx_ready`=1; accepts 4 bytes into the length register.
  - After the 4th byte:
    - N=0: go to DONE.
    - BASE_ADDR/4 + N > MEM_SIZE: go to ERR. Use a 33-bit compare so the sum cannot overflow.
    - Otherwise: go to DATA.
- DATA:
  - `rx_ready`=1; bytes shift into the assembly register, byte k goes to bits [8k+7:8k].
  - On the 4th byte: register `mem_wdata` and `mem_addr` = BASE_ADDR + 4×word_idx, then go to WRITE.
- WRITE:
  - `rx_ready`=0 and `mem_we`=1 for exactly one cycle.
  - word_idx increments. If the new word_idx equals N, go to DONE; otherwise go to DATA.
- DONE:
  - `done`=1 and `core_hold`=0; no bytes accepted.
  - `start` begins a new session (LEN) and clears `done`.
- ERR:
  - `err`=1 and `core_hold`=1; no bytes accepted, no writes.
  - `start` retries (LEN) and clears `err`.
- `core_hold`=1 in LEN, DATA, WRITE and ERR.
- `busy`=1 in LEN, DATA and WRITE.
- `start` is ignored in LEN, DATA and WRITE.
- Bytes offered while `rx_ready`=0 are not consumed; the source must hold them.
- There is no timeout: a stalled stream leaves the loader in LEN or DATA indefinitely.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_hold`=0, `busy`=0, `done`=0, `err`=0.
- `rx_ready`, `mem_we`, `core_hold` and `busy` decode combinationally from the state register. All other outputs are registered.
- `mem_we` rises in the cycle after the edge that accepts the 4th byte of a word. `mem_addr` and `mem_wdata` are stable whenever `mem_we`=1. The memory captures the write on the next edge.
- Peak throughput: 4 bytes per 5 cycles (4 transfer cycles plus 1 WRITE cycle).
- `done` or `err` becomes visible one cycle after the final WRITE cycle, or one cycle after the last length byte is accepted.
- Reset mid-session:
  - Immediate return to IDLE.
  - Any partially assembled word is discarded; words already written stay in memory.
  - `core_hold` drops during reset. The core's own reset must be asserted by the same `rst_n`.
- word_idx is ⌈log2(MEM_SIZE+1)⌉ bits wide and cannot wrap because of the LEN range check.

## Structure
- Shared package holds:
  - the state enum;
  - `BYTES_PER_WORD`=4;
  - the length-field width, 32.
- One sub-module: `word_packer`, a byte counter plus shift register with a `word_valid` pulse. It is reused for both the length field and payload words.
- The top level holds the FSM, word counter, range check and output registers.

## Test plan
- Reset: hold `rst_n`=0 and drive `rx_valid`=1 → all outputs at their reset values, no byte consumed.
- Two-word load:
  - Stimulus: `start`, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00.
  - Required: two writes, (0x0, 0x00000013) and (0x4, 0x00100093), each `mem_we` exactly 1 cycle.
  - Then `done`=1, `core_hold`=0.
- Empty program: N=0 (bytes 00 00 00 00) → no `mem_we`, `done`=1 one cycle after the 4th byte.
- Over-range and retry:
  - N=513 (01 02 00 00) with MEM_SIZE=512 → `err`=1, `core_hold`=1, no writes, further bytes refused.
  - `start` followed by a valid one-word frame → clean load, `err` clears.
- Backpressure and gaps: `rx_valid` toggling 1/0 each cycle in the two-word case → identical writes; no byte is lost or duplicated across WRITE cycles.
- Reset mid-load: assert `rst_n`=0 after 6 payload bytes → IDLE, no further `mem_we`. A following `start` plus full frame loads correctly from BASE_ADDR.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the program loader
package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream in and instruction-memory write port out
interface instr_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // loader side: consumes the stream, drives the memory write port
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  // environment side: byte source and instruction memory
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_loader_word_packer.sv
// rtl/instr_loader_word_packer.sv - little-endian byte-to-word assembler
module word_packer
  import instr_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic [LEN_WIDTH-1:0] word_o,
  output logic                 word_valid_o
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam int SW = 8 * (BYTES_PER_WORD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] shift_q, shift_d;

  // Only the earlier bytes are stored; the final byte completes the word
  // directly from the input so the owner can register it on the same edge.
  assign word_valid_o = byte_valid_i && (cnt_q == CW'(BYTES_PER_WORD - 1));
  assign word_o       = {byte_i, shift_q};

  // next byte count and shift contents; new bytes enter at the top
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 1'b1;
      shift_d = {byte_i, shift_q[SW-1:8]};
    end
  end

  // counter and shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads instruction memory from a length-prefixed byte stream
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_loader_if.master        bus,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int          IDX_W     = $clog2(MEM_SIZE + 1);
  localparam logic [32:0] BASE_WORD = 33'(BASE_ADDR / 4);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, err_q;

  logic                  rx_ready, mem_we;
  logic                  xfer, start_ok;
  logic [LEN_WIDTH-1:0]  pk_word;
  logic                  pk_valid;

  assign xfer     = bus.rx_valid && rx_ready;
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);

  word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (start_ok),
    .byte_valid_i(xfer),
    .byte_i      (bus.rx_data),
    .word_o      (pk_word),
    .word_valid_o(pk_valid)
  );

  // FSM next state, datapath next values and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    core_hold = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LEN;
          len_d   = '0;
          idx_d   = '0;
        end
      end
      ST_LEN: begin
        rx_ready  = 1'b1;
        core_hold = 1'b1;
        busy      = 1'b1;
        if (pk_valid) begin
          len_d = pk_word;
          // 33-bit sum so a huge count cannot wrap into the valid range
          if (pk_word == '0)                                 state_d = ST_DONE;
          else if (BASE_WORD + {1'b0, pk_word} > MEM_LIMIT)  state_d = ST_ERR;
          else                                               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready  = 1'b1;
        core_hold = 1'b1;
        busy      = 1'b1;
        if (pk_valid) begin
          wdata_d = DATA_WIDTH'(pk_word);
          addr_d  = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(idx_q) << 2);
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        core_hold = 1'b1;
        busy      = 1'b1;
        idx_d     = idx_q + 1'b1;
        state_d   = (LEN_WIDTH'(idx_d) == len_q) ? ST_DONE : ST_DATA;
      end
      ST_ERR: begin
        core_hold = 1'b1;
        if (start) begin
          state_d = ST_LEN;
          len_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

  localparam int MEM_SIZE  = 512;
  localparam int BASE_ADDR = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic core_hold, busy, done, err;

  instr_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  instr_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_SIZE  (MEM_SIZE),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .core_hold(core_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level model: counts bytes consumed in the session, derives N from the
  // first four, and predicts every write from the payload byte positions.
  bit              m_active = 0, m_done = 0, m_err = 0, m_we_pend = 0;
  int              m_nb = 0;
  longint unsigned m_len = 0;
  logic [31:0]     m_word = '0, m_exp_addr = '0, m_exp_data = '0;
  logic [31:0]     wlog_addr[$];
  logic [31:0]     wlog_data[$];

  always @(negedge clk) begin
    bit was_active;
    if (!rst_n) begin
      chk("reset_rx_ready",  bus.rx_ready,  0);
      chk("reset_mem_we",    bus.mem_we,    0);
      chk("reset_mem_addr",  bus.mem_addr,  0);
      chk("reset_mem_wdata", bus.mem_wdata, 0);
      chk("reset_core_hold", core_hold,     0);
      chk("reset_busy",      busy,          0);
      chk("reset_done",      done,          0);
      chk("reset_err",       err,           0);
      m_active = 0; m_done = 0; m_err = 0; m_we_pend = 0; m_nb = 0; m_len = 0;
    end else begin
      chk("rx_ready",  bus.rx_ready, m_active && !m_we_pend);
      chk("mem_we",    bus.mem_we,   m_we_pend);
      chk("busy",      busy,         m_active);
      chk("core_hold", core_hold,    m_active || m_err);
      chk("done",      done,         m_done);
      chk("err",       err,          m_err);
      if (bus.mem_we) begin
        wlog_addr.push_back(bus.mem_addr);
        wlog_data.push_back(bus.mem_wdata);
      end
      if (m_we_pend) begin
        chk("mem_addr",  bus.mem_addr,  m_exp_addr);
        chk("mem_wdata", bus.mem_wdata, m_exp_data);
      end
      was_active = m_active;
      if (m_we_pend) begin
        m_we_pend = 0;
        if (longint'(m_nb) == 4 + 4 * m_len) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (m_active && bus.rx_valid) begin
        m_nb++;
        if (m_nb <= 4) begin
          m_len = m_len | (longint'(bus.rx_data) << (8 * (m_nb - 1)));
          if (m_nb == 4) begin
            if (m_len == 0) begin
              m_active = 0; m_done = 1;
            end else if (longint'(BASE_ADDR / 4) + m_len > longint'(MEM_SIZE)) begin
              m_active = 0; m_err = 1;
            end
          end
        end else begin
          m_word = {bus.rx_data, m_word[31:8]};
          if ((m_nb - 4) % 4 == 0) begin
            m_we_pend  = 1;
            m_exp_addr = 32'(BASE_ADDR + (m_nb - 8));
            m_exp_data = m_word;
          end
        end
      end
      if (start && !was_active) begin
        m_active = 1; m_nb = 0; m_len = 0; m_done = 0; m_err = 0;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) break;
      t++;
      if (t > 50) begin
        errors++;
        $display("FAIL send_byte_timeout byte=%0h", b);
        break;
      end
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_seq(input logic [7:0] seq[], input bit gap);
    foreach (seq[i]) send_byte(seq[i], gap);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic check_two_word(input string tag);
    chk({tag, "_nwrites"}, wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      chk({tag, "_addr0"}, wlog_addr[0], 32'h0000_0000);
      chk({tag, "_data0"}, wlog_data[0], 32'h0000_0013);
      chk({tag, "_addr1"}, wlog_addr[1], 32'h0000_0004);
      chk({tag, "_data1"}, wlog_data[1], 32'h0010_0093);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hold"}, core_hold, 0);
  endtask

  logic [7:0] two_word[] = '{8'h02, 8'h00, 8'h00, 8'h00,
                             8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00};

  initial begin
    int nready;
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_lit", bus.rx_ready, 0);
    rst_n        = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;

    // two-word load, back to back
    clear_log();
    pulse_start();
    send_seq(two_word, 1'b0);
    settle();
    check_two_word("two_word");

    // empty program
    clear_log();
    pulse_start();
    send_seq('{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
    chk("empty_done_next_cycle", done, 1);
    settle();
    chk("empty_nwrites", wlog_addr.size(), 0);

    // over-range count 513, then retry with a one-word frame
    clear_log();
    pulse_start();
    send_seq('{8'h01, 8'h02, 8'h00, 8'h00}, 1'b0);
    chk("over_err", err, 1);
    chk("over_hold", core_hold, 1);
    bus.rx_data  = 8'hFF;
    bus.rx_valid = 1'b1;
    nready = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rx_ready) nready++;
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    chk("over_refused", nready, 0);
    chk("over_nwrites", wlog_addr.size(), 0);
    pulse_start();
    send_seq('{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);
    settle();
    chk("retry_nwrites", wlog_addr.size(), 1);
    if (wlog_addr.size() == 1) begin
      chk("retry_addr", wlog_addr[0], 32'h0000_0000);
      chk("retry_data", wlog_data[0], 32'hDDCC_BBAA);
    end
    chk("retry_err_clear", err, 0);
    chk("retry_done", done, 1);

    // same two-word frame with rx_valid gaps
    clear_log();
    pulse_start();
    send_seq(two_word, 1'b1);
    settle();
    check_two_word("gappy");

    // reset after six payload bytes, then a fresh load
    clear_log();
    pulse_start();
    send_seq('{8'h02, 8'h00, 8'h00, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    chk("midrst_nwrites", wlog_addr.size(), 1);
    if (wlog_addr.size() >= 1) chk("midrst_data0", wlog_data[0], 32'h4433_2211);
    chk("midrst_idle_busy", busy, 0);
    pulse_start();
    send_seq('{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 1'b0);
    settle();
    chk("reload_nwrites", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      chk("reload_addr", wlog_addr[1], 32'h0000_0000);
      chk("reload_data", wlog_data[1], 32'h1234_5678);
    end
    chk("reload_done", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
